bench_alu_pipe: RTL and testbench

Parametrised timing/functional bench harness around the existing `alu`. A serial-free command word is registered each cycle and drives a two-stage read/execute pipeline over a small register file. Explicit forwarding controls select between the register file and the previous ALU result, so the bypass path is exercised directly. A rotating XOR signature of all results is reduced to one output pin, which keeps synthesis from trimming the datapath and gives verification a single checkable value.

---
 rtl/bench_alu_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_bench_alu_pipe.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bench_alu_pipe.sv
// Bench harness: registered command word drives a read/execute pipeline around an RV-style ALU.
// A rotating XOR signature of all written results is reduced to the single tx pin.

module alu #(
  parameter int XLEN = 32
) (
  input  logic            sub_i,
  input  logic            ashr_i,
  input  logic [2:0]      funct3_i,
  input  logic            w_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] full_r;

  assign sh = b_i[SHW-1:0];

  always_comb begin
    full_r = '0;
    case (funct3_i)
      3'd0: full_r = sub_i ? a_i - b_i : a_i + b_i;
      3'd1: full_r = a_i << sh;
      3'd2: full_r = XLEN'($signed(a_i) < $signed(b_i));
      3'd3: full_r = XLEN'(a_i < b_i);
      3'd4: full_r = a_i ^ b_i;
      3'd5: begin
        if (ashr_i) full_r = $signed(a_i) >>> sh;
        else        full_r = a_i >> sh;
      end
      3'd6: full_r = a_i | b_i;
      3'd7: full_r = a_i & b_i;
      default: full_r = '0;
    endcase
  end

  if (XLEN == 64) begin : g_w
    // 32-bit word ops: low halves only, 5-bit shift, sign-extended result.
    logic [31:0] a32, b32, r32;
    logic [4:0]  sh32;

    assign a32  = a_i[31:0];
    assign b32  = b_i[31:0];
    assign sh32 = b_i[4:0];

    always_comb begin
      r32 = '0;
      case (funct3_i)
        3'd0: r32 = sub_i ? a32 - b32 : a32 + b32;
        3'd1: r32 = a32 << sh32;
        3'd2: r32 = 32'($signed(a32) < $signed(b32));
        3'd3: r32 = 32'(a32 < b32);
        3'd4: r32 = a32 ^ b32;
        3'd5: begin
          if (ashr_i) r32 = $signed(a32) >>> sh32;
          else        r32 = a32 >> sh32;
        end
        3'd6: r32 = a32 | b32;
        3'd7: r32 = a32 & b32;
        default: r32 = '0;
      endcase
    end

    assign result_o = w_i ? {{32{r32[31]}}, r32} : full_r;
  end else begin : g_nw
    logic unused_w;
    assign unused_w = w_i;
    assign result_o = full_r;
  end
endmodule

module bench_alu_pipe #(
  parameter  int XLEN      = 32,
  parameter  int NREGS     = 4,
  parameter  int FWD_STYLE = 0,
  parameter  int ZERO_REG  = 1,
  localparam int RW        = $clog2(NREGS),
  localparam int CMDW      = 3*RW + 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [CMDW-1:0] td,
  output logic            tx
);
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("bench_alu_pipe: XLEN must be 32 or 64");
  end
  if (NREGS < 2 || (1 << RW) != NREGS) begin : g_bad_nregs
    $error("bench_alu_pipe: NREGS must be a power of two >= 2");
  end

  typedef struct packed {
    logic          valid;
    logic          fwd1;
    logic          fwd2;
    logic          imm;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          w;
    logic          sub;
    logic          ashr;
    logic [2:0]    funct3;
  } cmd_t;

  cmd_t                       cmd_q;
  logic                       ex_valid_q, ex_w_q, ex_sub_q, ex_ashr_q;
  logic [RW-1:0]              ex_rd_q;
  logic [2:0]                 ex_f3_q;
  logic [XLEN-1:0]            op1, op2, result;
  logic [XLEN-1:0]            rs1_val, rs2_val, imm_val;
  logic [NREGS-1:0][XLEN-1:0] rf_q, rf_d;
  logic [XLEN-1:0]            sig_q, sig_d;
  logic                       tx_q;

  // Register-file reads see only state committed before this edge; bypass is explicit via fwd.
  assign rs1_val = rf_q[cmd_q.rs1];
  assign rs2_val = rf_q[cmd_q.rs2];
  assign imm_val = XLEN'(cmd_q.rs2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmd_q      <= '0;
      ex_valid_q <= 1'b0;
      ex_w_q     <= 1'b0;
      ex_sub_q   <= 1'b0;
      ex_ashr_q  <= 1'b0;
      ex_rd_q    <= '0;
      ex_f3_q    <= '0;
    end else begin
      cmd_q      <= cmd_t'(td);
      ex_valid_q <= cmd_q.valid;
      ex_w_q     <= cmd_q.w;
      ex_sub_q   <= cmd_q.sub;
      ex_ashr_q  <= cmd_q.ashr;
      ex_rd_q    <= cmd_q.rd;
      ex_f3_q    <= cmd_q.funct3;
    end
  end

  if (FWD_STYLE == 0) begin : g_mux
    logic [XLEN-1:0] op1_q, op2_q, op1_d, op2_d;

    assign op1_d = cmd_q.fwd1 ? result : rs1_val;
    assign op2_d = cmd_q.imm ? imm_val : (cmd_q.fwd2 ? result : rs2_val);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        op1_q <= '0;
        op2_q <= '0;
      end else begin
        op1_q <= op1_d;
        op2_q <= op2_d;
      end
    end

    assign op1 = op1_q;
    assign op2 = op2_q;
  end else begin : g_or
    // Each operand is split into a forward half and a file/immediate half; at most one is nonzero.
    logic [XLEN-1:0] op1f_q, op1r_q, op2f_q, op2r_q;
    logic [XLEN-1:0] op1f_d, op1r_d, op2f_d, op2r_d;

    assign op1f_d = cmd_q.fwd1 ? result : '0;
    assign op1r_d = cmd_q.fwd1 ? '0 : rs1_val;
    assign op2f_d = (!cmd_q.imm && cmd_q.fwd2) ? result : '0;
    assign op2r_d = cmd_q.imm ? imm_val : (cmd_q.fwd2 ? '0 : rs2_val);

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        op1f_q <= '0;
        op1r_q <= '0;
        op2f_q <= '0;
        op2r_q <= '0;
      end else begin
        op1f_q <= op1f_d;
        op1r_q <= op1r_d;
        op2f_q <= op2f_d;
        op2r_q <= op2r_d;
      end
    end

    assign op1 = op1f_q | op1r_q;
    assign op2 = op2f_q | op2r_q;
  end

  alu #(.XLEN(XLEN)) u_alu (
    .sub_i    (ex_sub_q),
    .ashr_i   (ex_ashr_q),
    .funct3_i (ex_f3_q),
    .w_i      (ex_w_q),
    .a_i      (op1),
    .b_i      (op2),
    .result_o (result)
  );

  always_comb begin
    rf_d  = rf_q;
    sig_d = sig_q;
    if (ex_valid_q) begin
      if (!(ZERO_REG != 0 && ex_rd_q == '0)) rf_d[ex_rd_q] = result;
      sig_d = {sig_q[XLEN-2:0], sig_q[XLEN-1]} ^ result;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_q  <= '0;
      sig_q <= '0;
      tx_q  <= 1'b0;
    end else begin
      rf_q  <= rf_d;
      sig_q <= sig_d;
      tx_q  <= sig_q[XLEN-1];
    end
  end

  assign tx = tx_q;
endmodule

// File: tb/tb_bench_alu_pipe.sv
// Four harness configurations share one command stream; each is checked every cycle
// against a command-level model, with directed literal checks on top.

module tb_bench_alu_pipe;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] td    = '0;
  logic        tx_s0, tx_s1, tx_w, tx_z;

  // 0: style 0, 1: style 1, 2: XLEN=64, 3: ZERO_REG=0
  bench_alu_pipe #(.XLEN(32), .NREGS(4), .FWD_STYLE(0), .ZERO_REG(1)) u_s0 (
    .clock(clock), .reset(reset), .td(td), .tx(tx_s0));
  bench_alu_pipe #(.XLEN(32), .NREGS(4), .FWD_STYLE(1), .ZERO_REG(1)) u_s1 (
    .clock(clock), .reset(reset), .td(td), .tx(tx_s1));
  bench_alu_pipe #(.XLEN(64), .NREGS(4), .FWD_STYLE(0), .ZERO_REG(1)) u_w (
    .clock(clock), .reset(reset), .td(td), .tx(tx_w));
  bench_alu_pipe #(.XLEN(32), .NREGS(4), .FWD_STYLE(0), .ZERO_REG(0)) u_z (
    .clock(clock), .reset(reset), .td(td), .tx(tx_z));

  always #5 clock = ~clock;

  logic        d_tx [4];
  logic [63:0] d_sig[4];
  logic [63:0] d_rf [4][4];

  assign d_tx[0] = tx_s0;
  assign d_tx[1] = tx_s1;
  assign d_tx[2] = tx_w;
  assign d_tx[3] = tx_z;
  assign d_sig[0] = 64'(u_s0.sig_q);
  assign d_sig[1] = 64'(u_s1.sig_q);
  assign d_sig[2] = 64'(u_w.sig_q);
  assign d_sig[3] = 64'(u_z.sig_q);
  for (genvar j = 0; j < 4; j++) begin : g_h
    assign d_rf[0][j] = 64'(u_s0.rf_q[j]);
    assign d_rf[1][j] = 64'(u_s1.rf_q[j]);
    assign d_rf[2][j] = 64'(u_w.rf_q[j]);
    assign d_rf[3][j] = 64'(u_z.rf_q[j]);
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int xl_of(input int i);
    return (i == 2) ? 64 : 32;
  endfunction

  function automatic bit zr_of(input int i);
    return i != 3;
  endfunction

  function automatic logic [63:0] rotl(input logic [63:0] s, input int xl);
    if (xl == 32) return {32'b0, s[30:0], s[31]};
    return {s[62:0], s[63]};
  endfunction

  // Reference ALU: plain arithmetic on 32- or 64-bit values.
  function automatic logic [63:0] alu_m(input int xl, input logic [15:0] c,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] x, y, r32;
    logic [63:0] r64;
    int s;
    r32 = '0;
    r64 = '0;
    if (xl == 32 || c[5]) begin
      x = a[31:0];
      y = b[31:0];
      s = int'(y[4:0]);
      case (c[2:0])
        3'd0: r32 = c[4] ? x - y : x + y;
        3'd1: r32 = x << s;
        3'd2: r32 = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: r32 = (x < y) ? 32'd1 : 32'd0;
        3'd4: r32 = x ^ y;
        3'd5: begin
          if (c[3]) r32 = $signed(x) >>> s;
          else      r32 = x >> s;
        end
        3'd6: r32 = x | y;
        default: r32 = x & y;
      endcase
      return (xl == 32) ? {32'b0, r32} : {{32{r32[31]}}, r32};
    end
    s = int'(b[5:0]);
    case (c[2:0])
      3'd0: r64 = c[4] ? a - b : a + b;
      3'd1: r64 = a << s;
      3'd2: r64 = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd3: r64 = (a < b) ? 64'd1 : 64'd0;
      3'd4: r64 = a ^ b;
      3'd5: begin
        if (c[3]) r64 = $signed(a) >>> s;
        else      r64 = a >> s;
      end
      3'd6: r64 = a | b;
      default: r64 = a & b;
    endcase
    return r64;
  endfunction

  // Command-level model: each command reads the file as of two commands back,
  // forwards from the immediately preceding result, and commits one command later.
  logic [63:0] m_rf[4][4];
  logic [63:0] m_sig[4];
  logic [63:0] m_prev[4];
  logic        m_tx[4];
  logic        p_valid;
  logic [1:0]  p_rd;
  logic [15:0] m_last;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_sig[i] = '0;
      m_prev[i] = '0;
      m_tx[i] = 1'b0;
      for (int j = 0; j < 4; j++) m_rf[i][j] = '0;
    end
    p_valid = 1'b0;
    p_rd = '0;
    m_last = '0;
  endtask

  task automatic model_step(input logic [15:0] cmd_now);
    logic [63:0] a, b, r;
    int xl;
    for (int i = 0; i < 4; i++) begin
      xl = xl_of(i);
      m_tx[i] = m_sig[i][xl-1];
      a = m_last[14] ? m_prev[i] : m_rf[i][m_last[9:8]];
      b = m_last[12] ? 64'(m_last[7:6]) : (m_last[13] ? m_prev[i] : m_rf[i][m_last[7:6]]);
      r = alu_m(xl, m_last, a, b);
      if (p_valid) begin
        if (!(zr_of(i) && p_rd == 2'd0)) m_rf[i][p_rd] = m_prev[i];
        m_sig[i] = rotl(m_sig[i], xl) ^ m_prev[i];
      end
      m_prev[i] = r;
    end
    p_valid = m_last[15];
    p_rd = m_last[11:10];
    m_last = cmd_now;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (reset) model_clear();
      else model_step(td);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("tx[%0d]", i), 64'(d_tx[i]), 64'(m_tx[i]));
        chk($sformatf("sig[%0d]", i), d_sig[i], m_sig[i]);
        for (int j = 0; j < 4; j++)
          chk($sformatf("rf[%0d][%0d]", i, j), d_rf[i][j], m_rf[i][j]);
      end
    end
  end

  function automatic logic [15:0] mk(input bit v, input bit f1, input bit f2, input bit im,
                                     input int rd, input int rs1, input int rs2,
                                     input bit w, input bit sub, input bit ashr, input int f3);
    return {v, f1, f2, im, 2'(rd), 2'(rs1), 2'(rs2), w, sub, ashr, 3'(f3)};
  endfunction

  task automatic issue(input logic [15:0] c);
    td = c;
    @(negedge clock);
  endtask

  task automatic run1(input logic [15:0] c);
    issue(c);
    td = '0;
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    td = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic mid_reset();
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("async_rst_sig", d_sig[i], 64'd0);
      chk("async_rst_tx", 64'(d_tx[i]), 64'd0);
      for (int j = 0; j < 4; j++) chk("async_rst_rf", d_rf[i][j], 64'd0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  localparam logic [63:0] ONES32 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    logic [15:0] c;
    do_reset();
    repeat (20) @(negedge clock);
    for (int j = 0; j < 4; j++) chk("idle_rf", d_rf[0][j], 64'd0);
    chk("idle_sig", d_sig[2], 64'd0);
    chk("idle_tx", 64'(d_tx[0]), 64'd0);

    // r1 = r0 + 3, then r2 = r1 + r1 through the bypass
    do_reset();
    issue(mk(1, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0));
    issue(mk(1, 1, 1, 0, 2, 1, 1, 0, 0, 0, 0));
    td = '0;
    chk("lat_r1_early", d_rf[0][1], 64'd0);
    @(negedge clock);
    chk("lat_r1", d_rf[0][1], 64'd3);
    chk("lat_r2_early", d_rf[1][2], 64'd0);
    @(negedge clock);
    chk("fwd_r2_s0", d_rf[0][2], 64'd6);
    chk("fwd_r2_s1", d_rf[1][2], 64'd6);
    chk("fwd_r2_w", d_rf[2][2], 64'd6);
    chk("model_fwd_r2", m_rf[0][2], 64'd6);

    // same dependency without fwd reads the stale r1
    do_reset();
    issue(mk(1, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0));
    issue(mk(1, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0));
    td = '0;
    repeat (3) @(negedge clock);
    chk("nofwd_r1", d_rf[0][1], 64'd3);
    chk("nofwd_r2", d_rf[0][2], 64'd0);

    do_reset();
    run1(mk(1, 0, 0, 1, 3, 0, 1, 0, 1, 0, 0));
    chk("sub_r3_32", d_rf[0][3], ONES32);
    chk("sub_r3_64", d_rf[2][3], ONES64);
    chk("sub_sig", d_sig[0], ONES32);
    chk("sub_tx", 64'(d_tx[0]), 64'd1);
    run1(mk(1, 0, 0, 1, 1, 3, 1, 0, 0, 1, 5));
    chk("sra_32", d_rf[1][1], ONES32);
    chk("sra_64", d_rf[2][1], ONES64);
    run1(mk(1, 0, 0, 1, 2, 3, 1, 0, 0, 0, 5));
    chk("srl_32", d_rf[0][2], 64'h0000_0000_7FFF_FFFF);
    chk("srl_64", d_rf[2][2], 64'h7FFF_FFFF_FFFF_FFFF);
    run1(mk(1, 0, 0, 1, 2, 3, 1, 1, 0, 0, 5));
    chk("srlw_64", d_rf[2][2], 64'h0000_0000_7FFF_FFFF);
    chk("srlw_32", d_rf[1][2], 64'h0000_0000_7FFF_FFFF);
    run1(mk(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 2));
    chk("slt_32", d_rf[0][1], 64'd1);
    chk("slt_64", d_rf[2][1], 64'd1);
    run1(mk(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 3));
    chk("sltu_32", d_rf[0][1], 64'd0);

    // r0 handling and invalid commands
    do_reset();
    run1(mk(1, 0, 0, 1, 0, 0, 3, 0, 0, 0, 0));
    chk("zr1_r0", d_rf[0][0], 64'd0);
    chk("zr0_r0", d_rf[3][0], 64'd3);
    chk("zr1_sig", d_sig[0], 64'd3);
    run1(mk(0, 0, 0, 1, 1, 0, 2, 0, 0, 0, 0));
    chk("inv_r1", d_rf[3][1], 64'd0);
    chk("inv_sig", d_sig[3], 64'd3);

    // random stream with a reset in the middle
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      c = 16'($urandom);
      c[15] = ($urandom_range(0, 7) != 0);
      issue(c);
      if (n == 500) mid_reset();
    end
    td = '0;
    repeat (4) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
